// File: rtl/fifo_serial_pkg.sv
// Shared types and constants for the FIFO serial drain path.
package fifo_serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned DSIZE_DEF     = 4;
  localparam int unsigned PARITY_EN_DEF = 1;
  localparam int unsigned FRAME_BITS    = 2 + DSIZE_DEF + PARITY_EN_DEF;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter; flags the last cycle of each serial bit.
module bit_timer
  import fifo_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end,
  output logic bit_end_next
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;

  // Next count: wrap at the end of a bit, hold at zero while cleared.
  always_comb begin
    if (clear || (cnt_r == LAST_CNT)) begin
      cnt_next_s = {CW{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CW'(1);
    end
  end

  assign bit_end      = (cnt_r == LAST_CNT);
  assign bit_end_next = (cnt_next_s == LAST_CNT);

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a FWFT FIFO and sends each as a UART-like frame on txd:
// start, data LSB-first, optional even parity, stop.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int unsigned DSIZE        = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             empty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             txd,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BW = cnt_width(DSIZE + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DSIZE - 1);

  tx_state_e        state_r, state_next_s;
  logic [DSIZE-1:0] shift_r, shift_next_s;
  logic             parity_r, parity_next_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_next_s;
  logic             txd_r, txd_next_s;
  logic             busy_r, busy_next_s;
  logic             frame_done_r, frame_done_next_s;
  logic             rinc_s, clear_s, bit_end_s, bit_end_next_s;

  function automatic logic even_parity(input logic [DSIZE-1:0] d);
    return ^d;
  endfunction

  // Gated by rst_n so no pop is requested while the block is held in reset.
  assign rinc_s  = rst_n & (state_r == IDLE) & en & ~empty;
  assign clear_s = (state_r == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear_s),
    .bit_end     (bit_end_s),
    .bit_end_next(bit_end_next_s)
  );

  // Frame sequencing: next state, shift register, parity and data-bit count.
  always_comb begin
    state_next_s   = state_r;
    shift_next_s   = shift_r;
    parity_next_s  = parity_r;
    bit_cnt_next_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (rinc_s) begin
          state_next_s   = START;
          shift_next_s   = rdata;
          parity_next_s  = even_parity(rdata);
          bit_cnt_next_s = {BW{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) state_next_s = DATA;
        else           state_next_s = START;
      end
      DATA: begin
        if (bit_end_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_next_s = {BW{1'b0}};
            state_next_s   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_next_s = bit_cnt_r + BW'(1);
            shift_next_s   = shift_r >> 1;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) state_next_s = STOP;
        else           state_next_s = PARITY;
      end
      STOP: begin
        if (bit_end_s) state_next_s = IDLE;
        else           state_next_s = STOP;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Outputs are derived from the upcoming state so the registers line up with state_r.
  always_comb begin
    txd_next_s        = 1'b1;
    busy_next_s       = (state_next_s != IDLE);
    frame_done_next_s = (state_next_s == STOP) && bit_end_next_s;
    case (state_next_s)
      IDLE:    txd_next_s = 1'b1;
      START:   txd_next_s = 1'b0;
      DATA:    txd_next_s = shift_next_s[0];
      PARITY:  txd_next_s = parity_next_s;
      STOP:    txd_next_s = 1'b1;
      default: txd_next_s = 1'b1;
    endcase
  end

  // State and output registers; reset aborts any frame and idles txd high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      shift_r      <= {DSIZE{1'b0}};
      parity_r     <= 1'b0;
      bit_cnt_r    <= {BW{1'b0}};
      txd_r        <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      shift_r      <= shift_next_s;
      parity_r     <= parity_next_s;
      bit_cnt_r    <= bit_cnt_next_s;
      txd_r        <= txd_next_s;
      busy_r       <= busy_next_s;
      frame_done_r <= frame_done_next_s;
    end
  end

  assign rinc       = rinc_s;
  assign txd        = txd_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Self-checking bench: a FIFO model feeds the DUT and a frame-level model predicts txd/busy/frame_done/rinc.
module tb_fifo_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en1, empty1, rinc1, txd1, busy1, fd1;
  logic [3:0] rdata1;
  logic       en2, empty2, rinc2, txd2, busy2, fd2;
  logic [3:0] rdata2;

  fifo_serial_tx #(.DSIZE(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en1), .empty(empty1), .rdata(rdata1),
    .rinc(rinc1), .txd(txd1), .busy(busy1), .frame_done(fd1)
  );

  fifo_serial_tx #(.DSIZE(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .empty(empty2), .rdata(rdata2),
    .rinc(rinc2), .txd(txd2), .busy(busy2), .frame_done(fd2)
  );

  int errors = 0;
  int checks = 0;
  int rinc_cnt = 0;
  logic [3:0] fifo_q[$];
  logic [2:0] exp_q[$];   // {txd, busy, frame_done} per cycle
  bit hold = 1'b0;        // forces empty=1 even when the model FIFO has data
  bit en_want1 = 1'b0;
  bit en_want2 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle outputs of a whole frame, built from the bit list.
  task automatic push_frame(input logic [3:0] w, input int cpb, input bit par);
    bit bits[$];
    bit fdb;
    bits.push_back(1'b0);
    for (int i = 0; i < 4; i++) bits.push_back(w[i]);
    if (par) bits.push_back(^w);
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int j = 0; j < cpb; j++) begin
        fdb = (k == bits.size() - 1) && (j == cpb - 1);
        exp_q.push_back({bits[k], 1'b1, fdb});
      end
    end
  endtask

  // One clock: drive FIFO side at negedge, compare, advance the model.
  task automatic cycle(input int sel);
    logic e, t_o, b_o, f_o, r_o, en_o;
    logic [2:0] exp;
    bit exp_rinc;
    @(negedge clk);
    e = hold || (fifo_q.size() == 0);
    if (sel == 1) begin
      en1 = en_want1; empty1 = e; rdata1 = e ? 4'($urandom) : fifo_q[0];
    end else begin
      en2 = en_want2; empty2 = e; rdata2 = e ? 4'($urandom) : fifo_q[0];
    end
    #1;
    if (sel == 1) begin t_o = txd1; b_o = busy1; f_o = fd1; r_o = rinc1; en_o = en1; end
    else          begin t_o = txd2; b_o = busy2; f_o = fd2; r_o = rinc2; en_o = en2; end
    exp = (exp_q.size() != 0) ? exp_q[0] : 3'b100;
    check("txd", {31'd0, t_o}, {31'd0, exp[2]});
    check("busy", {31'd0, b_o}, {31'd0, exp[1]});
    check("frame_done", {31'd0, f_o}, {31'd0, exp[0]});
    exp_rinc = (exp_q.size() == 0) && en_o && !e;
    check("rinc", {31'd0, r_o}, {31'd0, exp_rinc});
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (exp_rinc) begin
      rinc_cnt++;
      if (sel == 1) push_frame(fifo_q.pop_front(), 4, 1'b1);
      else          push_frame(fifo_q.pop_front(), 1, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; en1 = 1'b1; empty1 = 1'b0; rdata1 = 4'hA;
    en2 = 1'b0; empty2 = 1'b1; rdata2 = 4'h0;

    // Reset with a pending word and enable
    repeat (3) @(negedge clk);
    #1;
    check("rst_txd", {31'd0, txd1}, 32'd1);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_rinc", {31'd0, rinc1}, 32'd0);
    check("rst_fd", {31'd0, fd1}, 32'd0);
    check("rst_txd2", {31'd0, txd2}, 32'd1);
    @(negedge clk);
    empty1 = 1'b1; en_want1 = 1'b1;
    rst_n = 1'b1;

    // Single word 1011
    rinc_cnt = 0;
    fifo_q.push_back(4'b1011);
    repeat (35) cycle(1);
    check("single_pops", rinc_cnt, 32'd1);

    // Back-to-back 3 then C
    rinc_cnt = 0;
    fifo_q.push_back(4'h3); fifo_q.push_back(4'hC);
    repeat (65) cycle(1);
    check("b2b_pops", rinc_cnt, 32'd2);

    // Enable gating
    rinc_cnt = 0;
    en_want1 = 1'b0;
    fifo_q.push_back(4'h5); fifo_q.push_back(4'h6);
    repeat (20) cycle(1);
    check("en_off_pops", rinc_cnt, 32'd0);
    en_want1 = 1'b1;
    cycle(1);
    repeat (10) cycle(1);
    en_want1 = 1'b0;
    repeat (40) cycle(1);
    check("en_drop_pops", rinc_cnt, 32'd1);
    check("en_drop_left", fifo_q.size(), 32'd1);
    fifo_q.delete();

    // Reset mid-frame
    en_want1 = 1'b1;
    fifo_q.push_back(4'h9);
    repeat (7) cycle(1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_txd", {31'd0, txd1}, 32'd1);
    check("midrst_busy", {31'd0, busy1}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1);

    // Empty rises during DATA
    rinc_cnt = 0;
    fifo_q.push_back(4'h6); fifo_q.push_back(4'h7);
    repeat (10) cycle(1);
    hold = 1'b1;
    repeat (40) cycle(1);
    check("hold_pops", rinc_cnt, 32'd1);
    hold = 1'b0;
    repeat (35) cycle(1);
    check("release_pops", rinc_cnt, 32'd2);

    // No parity, one clock per bit
    en_want1 = 1'b0;
    cycle(1);
    rinc_cnt = 0;
    en_want2 = 1'b1;
    fifo_q.push_back(4'hF);
    repeat (10) cycle(2);
    check("np_pops", rinc_cnt, 32'd1);
    fifo_q.push_back(4'h2); fifo_q.push_back(4'hD);
    repeat (16) cycle(2);
    check("np_b2b_pops", rinc_cnt, 32'd3);
    en_want2 = 1'b0;
    cycle(2);

    // Randomized traffic on the main instance
    en_want1 = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (fifo_q.size() < 4 && $urandom_range(3, 0) == 0) fifo_q.push_back(4'($urandom));
      if ($urandom_range(19, 0) == 0) en_want1 = ~en_want1;
      hold = ($urandom_range(7, 0) == 0);
      cycle(1);
    end
    hold = 1'b0; en_want1 = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (fifo_q.size() == 0 && exp_q.size() == 0) break;
      cycle(1);
    end
    check("drain_fifo", fifo_q.size(), 32'd0);
    check("drain_frame", exp_q.size(), 32'd0);
    repeat (3) cycle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
